// File: rtl/reg_wb_if.sv
// Write-back arbiter bus: source request lanes, register-file write port and
// the forwarding lookup (fwd_* is only meaningful when built with WB_FWD_EN).
interface reg_wb_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      wb_stall;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [CNT_W-1:0]          wr_count;
  logic [ADDR_W-1:0]         fwd_addr;
  logic                      fwd_hit;
  logic [DATA_W-1:0]         fwd_data;

  modport master (
    output src_valid, src_addr, src_data, wb_stall, fwd_addr,
    input  src_ready, wr_en, wr_addr, wr_data, wr_count, fwd_hit, fwd_data
  );
  modport slave (
    input  src_valid, src_addr, src_data, wb_stall, fwd_addr,
    output src_ready, wr_en, wr_addr, wr_data, wr_count, fwd_hit, fwd_data
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter feeding one registered register-file write port.
// Define WB_FWD_EN to build the last-write history and the fwd_* lookup.
module reg_wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input logic      clk,
  input logic      reset,
  reg_wb_if.slave  bus
);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_SRC-1:0][DATA_W-1:0] data_a;
  logic [PTR_W-1:0]               rr_ptr, gidx;
  logic [NUM_SRC-1:0]             gnt;
  logic                           found, accept;
  logic                           wr_en_q;
  logic [ADDR_W-1:0]              wr_addr_q;
  logic [DATA_W-1:0]              wr_data_q;
  logic [CNT_W-1:0]               wr_count_q;

  assign addr_a = bus.src_addr;
  assign data_a = bus.src_data;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return PTR_W'(s);
  endfunction

  // Scan from rr_ptr upward (mod NUM_SRC); first valid source wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    if (!reset && !bus.wb_stall) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!found && bus.src_valid[wrap_idx(rr_ptr, k)]) begin
          found = 1'b1;
          gidx  = wrap_idx(rr_ptr, k);
        end
      end
    end
    gnt = found ? (NUM_SRC'(1) << gidx) : '0;
  end

  assign bus.src_ready = gnt;
  assign accept        = |(bus.src_valid & gnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      rr_ptr     <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q  <= addr_a[gidx];
        wr_data_q  <= data_a[gidx];
        wr_count_q <= wr_count_q + 1'b1;
        rr_ptr     <= (gidx == PTR_W'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_count = wr_count_q;

`ifdef WB_FWD_EN
  logic              hist_valid;
  logic [ADDR_W-1:0] hist_addr;
  logic [DATA_W-1:0] hist_data;

  // History trails the write port by one edge, so it holds what the
  // register file committed most recently.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_valid <= 1'b0;
      hist_addr  <= '0;
      hist_data  <= '0;
    end else if (wr_en_q) begin
      hist_valid <= 1'b1;
      hist_addr  <= wr_addr_q;
      hist_data  <= wr_data_q;
    end
  end

  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    if (wr_en_q && wr_addr_q == bus.fwd_addr) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = wr_data_q;
    end else if (hist_valid && hist_addr == bus.fwd_addr) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = hist_data;
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^bus.fwd_addr;
  assign bus.fwd_hit     = 1'b0;
  assign bus.fwd_data    = '0;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed + randomized bench for reg_wb_arbiter against a queue-free
// behavioural model of the grant/write/history rules.
module tb_reg_wb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;   // narrow counter so wrap-around is exercised

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_wb_if #(.NUM_SRC(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus();

  reg_wb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          m_ptr = 0;
  logic        m_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int          m_cnt = 0;
  logic        h_v = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_data = '0;
  int          last_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (reset || bus.wb_stall) return -1;
    for (int k = 0; k < N; k++) begin
      if (bus.src_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.src_valid[i] = 1'b1;
    bus.src_addr[i*AW +: AW] = a;
    bus.src_data[i*DW +: DW] = d;
  endtask

  // One clock: inputs already driven (at negedge); returns at next negedge.
  task automatic step();
    int g;
    logic [N-1:0] er;
    logic          ehit;
    logic [DW-1:0] edata;
    #1;
    g  = model_grant();
    er = (g >= 0) ? (N'(1) << g) : '0;
    check("src_ready", 64'(bus.src_ready), 64'(er));
    last_g = g;
    @(posedge clk);
    #1;
    if (reset) begin
      m_en = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_ptr = 0;
      h_v = 1'b0; h_addr = '0; h_data = '0;
    end else begin
      if (m_en) begin h_v = 1'b1; h_addr = m_addr; h_data = m_data; end
      if (g >= 0) begin
        m_en   = 1'b1;
        m_addr = bus.src_addr[g*AW +: AW];
        m_data = bus.src_data[g*DW +: DW];
        m_cnt  = (m_cnt + 1) % (1 << CW);
        m_ptr  = (g + 1) % N;
      end else begin
        m_en = 1'b0;
      end
    end
    check("wr_en",    64'(bus.wr_en),    64'(m_en));
    check("wr_addr",  64'(bus.wr_addr),  64'(m_addr));
    check("wr_data",  64'(bus.wr_data),  64'(m_data));
    check("wr_count", 64'(bus.wr_count), 64'(m_cnt));
    ehit = 1'b0; edata = '0;
`ifdef WB_FWD_EN
    if (m_en && m_addr == bus.fwd_addr) begin ehit = 1'b1; edata = m_data; end
    else if (h_v && h_addr == bus.fwd_addr) begin ehit = 1'b1; edata = h_data; end
`endif
    check("fwd_hit",  64'(bus.fwd_hit),  64'(ehit));
    check("fwd_data", 64'(bus.fwd_data), 64'(edata));
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) step();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.src_valid = '0;
    bus.src_addr  = '0;
    bus.src_data  = '0;
    bus.wb_stall  = 1'b0;
    bus.fwd_addr  = '0;
    last_g        = -1;

    // reset then idle
    do_reset(2);
    check("idle_count", 64'(bus.wr_count), 64'd0);
    step();

    // single request from source 1
    set_src(1, 5'd26, 32'h12345678);
    step();
    check("single_grant", 64'(last_g), 64'd1);
    check("single_addr", 64'(bus.wr_addr), 64'd26);
    bus.src_valid = '0;
    step();
    check("single_drop", 64'(bus.wr_en), 64'd0);

    // round-robin with all sources held valid for 8 cycles
    do_reset(1);
    for (int i = 0; i < N; i++) set_src(i, AW'(i + 1), DW'(32'h100 + i));
    for (int c = 0; c < 8; c++) begin
      step();
      check("rr_order", 64'(last_g), 64'(c % N));
    end
    bus.src_valid = '0;
    check("rr_count", 64'(bus.wr_count), 64'd8);
    step();

    // stall with two sources on the same address
    set_src(0, 5'd5, 32'hA);
    set_src(2, 5'd5, 32'hB);
    bus.wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) step();
    bus.wb_stall = 1'b0;
    step();
    check("conflict_first", 64'(bus.wr_data), 64'hA);
    bus.src_valid[0] = 1'b0;
    step();
    check("conflict_second", 64'(bus.wr_data), 64'hB);
    bus.src_valid = '0;
    step();

    // reset in the middle of a stream
    for (int i = 0; i < N; i++) set_src(i, AW'(i + 9), DW'(32'h200 + i));
    step(); step();
    do_reset(1);
    check("midreset_count", 64'(bus.wr_count), 64'd0);
    step();
    check("midreset_first", 64'(last_g), 64'd0);
    bus.src_valid = '0;
    step();

    // forwarding lookup
    set_src(0, 5'd7, 32'hDEAD);
    step();
    bus.src_valid = '0;
    bus.fwd_addr  = 5'd7;
    step(); step(); step();
    bus.fwd_addr  = 5'd8;
    step();

    // randomized traffic: stalls, sparse resets, address/forwarding collisions
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!bus.src_valid[i] && $urandom_range(0, 2) == 0)
          set_src(i, AW'($urandom_range(0, 7)), DW'($urandom));
      bus.wb_stall = ($urandom_range(0, 4) == 0);
      reset        = ($urandom_range(0, 39) == 0);
      bus.fwd_addr = AW'($urandom_range(0, 7));
      step();
      if (last_g >= 0) bus.src_valid[last_g] = 1'b0;
    end
    reset        = 1'b0;
    bus.wb_stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
